// File: rtl/channel_filter_pkg.sv
// Shared constants and helpers for the pipelined channel filter.
package channel_filter_pkg;

  localparam int GROUP_SIZE = 8;

  // Accumulator width wide enough for depth signed taps, including negation of the most negative tap.
  function automatic int acc_width(input int est_channel_bitwidth, input int depth);
    return est_channel_bitwidth + $clog2(depth) + 1;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int code_bitwidth,
                                                  output logic clipped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] result;
    hi = (64'sd1 <<< (code_bitwidth - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (code_bitwidth - 1));
    if (value > hi) begin
      result  = hi;
      clipped = 1'b1;
    end else if (value < lo) begin
      result  = lo;
      clipped = 1'b1;
    end else begin
      result  = value;
      clipped = 1'b0;
    end
    return result;
  endfunction

endpackage

// File: rtl/channel_filter_lane.sv
// One lane: grouped partial sums (stage 1), then final sum, shift and saturation (stage 2).
module channel_filter_lane
  import channel_filter_pkg::*;
#(
  parameter int depth                = 30,
  parameter int est_channel_bitwidth = 8,
  parameter int est_code_bitwidth    = 8,
  parameter int shift_bitwidth       = 2
) (
  input  logic                                   clk,
  input  logic                                   rstb,
  input  logic                                   load,
  input  logic                                   update,
  input  logic        [depth-1:0]                win,
  input  logic signed [est_channel_bitwidth-1:0] taps [depth],
  input  logic        [shift_bitwidth-1:0]       shift,
  output logic signed [est_code_bitwidth-1:0]    est_code,
  output logic                                   sat_flag
);

  localparam int ACC_W      = acc_width(est_channel_bitwidth, depth);
  localparam int NUM_GROUPS = (depth + GROUP_SIZE - 1) / GROUP_SIZE;

  logic signed [ACC_W-1:0] part_d [NUM_GROUPS];
  logic signed [ACC_W-1:0] part_q [NUM_GROUPS];
  logic signed [ACC_W-1:0] tap_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic signed [63:0]      sat_val;
  logic                    clip;

  // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
  always_comb begin
    tap_ext = '0;
    for (int g = 0; g < NUM_GROUPS; g++) part_d[g] = '0;
    for (int t = 0; t < depth; t++) begin
      tap_ext = ACC_W'(taps[t]);
      part_d[t / GROUP_SIZE] += win[t] ? tap_ext : -tap_ext;
    end
  end

  always_comb begin
    acc = '0;
    for (int g = 0; g < NUM_GROUPS; g++) acc += part_q[g];
    shifted = acc >>> shift;
    sat_val = saturate(64'(shifted), est_code_bitwidth, clip);
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int g = 0; g < NUM_GROUPS; g++) part_q[g] <= '0;
    end else if (load) begin
      part_q <= part_d;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      est_code <= '0;
      sat_flag <= 1'b0;
    end else if (update) begin
      est_code <= sat_val[est_code_bitwidth-1:0];
      sat_flag <= clip;
    end
  end

endmodule

// File: rtl/channel_filter_pipe.sv
// Streaming channel filter: owns taps, bit history, valid pipeline and tap-write decode.
module channel_filter_pipe
  import channel_filter_pkg::*;
#(
  parameter int width                = 16,
  parameter int depth                = 30,
  parameter int est_channel_bitwidth = 8,
  parameter int est_code_bitwidth    = 8,
  parameter int shift_bitwidth       = 2
) (
  input  logic                                  clk,
  input  logic                                  rstb,
  input  logic                                  in_valid,
  input  logic [width-1:0]                      bits_in,
  input  logic                                  flush,
  input  logic                                  coef_we,
  input  logic                                  coef_bcast,
  input  logic [$clog2(width)-1:0]              coef_lane,
  input  logic [$clog2(depth)-1:0]              coef_tap,
  input  logic signed [est_channel_bitwidth-1:0] coef_data,
  input  logic [width*shift_bitwidth-1:0]       shift,
  output logic                                  out_valid,
  output logic [width*est_code_bitwidth-1:0]    est_code,
  output logic [width-1:0]                      sat_flag
);

  logic signed [est_channel_bitwidth-1:0] coef [width][depth];
  logic [depth-2:0]       hist;
  logic [depth+width-2:0] win;
  logic                   stage1_valid;

  assign win = {bits_in, hist};

  // NOTE: the tap array is reset explicitly because a cleared filter must produce zero codes after reset.
  // Out-of-range lane/tap addresses simply match no register, so such writes are dropped.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int l = 0; l < width; l++)
        for (int t = 0; t < depth; t++) coef[l][t] <= '0;
    end else if (coef_we) begin
      for (int l = 0; l < width; l++)
        for (int t = 0; t < depth; t++)
          if ((coef_bcast || int'(coef_lane) == l) && int'(coef_tap) == t)
            coef[l][t] <= coef_data;
    end
  end

  // Flush wins over advance; a frame in the flush cycle already used the old history.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      hist         <= '0;
      stage1_valid <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      if (flush)         hist <= '0;
      else if (in_valid) hist <= win[width +: depth-1];
      stage1_valid <= in_valid;
      out_valid    <= stage1_valid;
    end
  end

  for (genvar i = 0; i < width; i++) begin : g_lane
    logic [depth-1:0] lane_win;

    always_comb begin
      for (int t = 0; t < depth; t++) lane_win[t] = win[i+depth-1-t];
    end

    channel_filter_lane #(
      .depth               (depth),
      .est_channel_bitwidth(est_channel_bitwidth),
      .est_code_bitwidth   (est_code_bitwidth),
      .shift_bitwidth      (shift_bitwidth)
    ) u_lane (
      .clk     (clk),
      .rstb    (rstb),
      .load    (in_valid),
      .update  (stage1_valid),
      .win     (lane_win),
      .taps    (coef[i]),
      .shift   (shift[i*shift_bitwidth +: shift_bitwidth]),
      .est_code(est_code[i*est_code_bitwidth +: est_code_bitwidth]),
      .sat_flag(sat_flag[i])
    );
  end

endmodule

// File: tb/tb_channel_filter_pipe.sv
// Directed self-checking bench for channel_filter_pipe with hand-computed expected codes.
module tb_channel_filter_pipe;

  logic               clk = 1'b0;
  logic               rstb;
  logic               in_valid;
  logic [15:0]        bits_in;
  logic               flush;
  logic               coef_we;
  logic               coef_bcast;
  logic [3:0]         coef_lane;
  logic [4:0]         coef_tap;
  logic signed [7:0]  coef_data;
  logic [31:0]        shift;
  logic               out_valid;
  logic [127:0]       est_code;
  logic [15:0]        sat_flag;

  int checks = 0;
  int errors = 0;

  channel_filter_pipe u_dut (
    .clk       (clk),
    .rstb      (rstb),
    .in_valid  (in_valid),
    .bits_in   (bits_in),
    .flush     (flush),
    .coef_we   (coef_we),
    .coef_bcast(coef_bcast),
    .coef_lane (coef_lane),
    .coef_tap  (coef_tap),
    .coef_data (coef_data),
    .shift     (shift),
    .out_valid (out_valid),
    .est_code  (est_code),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] code(input int lane);
    return 32'($signed(est_code[lane*8 +: 8]));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tap(input logic bcast, input logic [3:0] lane, input logic [4:0] tap,
                           input logic signed [7:0] data);
    coef_we    = 1'b1;
    coef_bcast = bcast;
    coef_lane  = lane;
    coef_tap   = tap;
    coef_data  = data;
    tick();
    coef_we    = 1'b0;
    coef_bcast = 1'b0;
  endtask

  task automatic broadcast_all(input logic signed [7:0] data);
    for (int t = 0; t < 30; t++) write_tap(1'b1, 4'd0, 5'(t), data);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // One isolated frame; returns when its result is visible on the outputs.
  task automatic run_frame(input logic [15:0] bits);
    in_valid = 1'b1;
    bits_in  = bits;
    tick();
    in_valid = 1'b0;
    bits_in  = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rstb = 1'b0; in_valid = 1'b0; bits_in = '0; flush = 1'b0;
    coef_we = 1'b0; coef_bcast = 1'b0; coef_lane = '0; coef_tap = '0; coef_data = '0;
    shift = '0;
    tick(); tick();
    check("reset out_valid", 32'(out_valid), 0);
    check("reset est_code lane0", code(0), 0);
    check("reset sat_flag", 32'(sat_flag), 0);
    rstb = 1'b1;
    tick();

    // Tap 0 only: each lane echoes its own bit, two-cycle latency, single-cycle valid pulse.
    write_tap(1'b1, 4'd0, 5'd0, 8'sd10);
    in_valid = 1'b1; bits_in = 16'hFFFF;
    tick();
    in_valid = 1'b0; bits_in = '0;
    check("t1 latency out_valid", 32'(out_valid), 0);
    tick();
    check("t1 out_valid", 32'(out_valid), 1);
    for (int i = 0; i < 16; i++) check($sformatf("t1 lane%0d", i), code(i), 10);
    check("t1 sat_flag", 32'(sat_flag), 0);
    tick();
    check("t1 pulse end", 32'(out_valid), 0);

    // Tap 1 only: lane i sees lane i-1's bit; lane 0 sees the previous frame's last bit.
    write_tap(1'b1, 4'd0, 5'd0, 8'sd0);
    write_tap(1'b1, 4'd0, 5'd1, 8'sd5);
    in_valid = 1'b1; bits_in = 16'hFFFF;
    tick();
    bits_in = 16'h0000;
    tick();
    in_valid = 1'b0;
    check("t2 A out_valid", 32'(out_valid), 1);
    for (int i = 0; i < 16; i++) check($sformatf("t2 A lane%0d", i), code(i), 5);
    tick();
    check("t2 B out_valid", 32'(out_valid), 1);
    check("t2 B lane0", code(0), 5);
    for (int i = 1; i < 16; i++) check($sformatf("t2 B lane%0d", i), code(i), -5);
    do_flush();
    shift = 32'h0000_0001;
    run_frame(16'h0000);
    check("t2 flush lane0 shift1 floor", code(0), -3);
    check("t2 flush lane7", code(7), -5);
    check("t2 flush sat_flag", 32'(sat_flag), 0);
    shift = '0;

    // All taps 100 with shift 2: +-3000 -> +-750 clips both ways.
    broadcast_all(8'sd100);
    shift = 32'hAAAA_AAAA;
    run_frame(16'hFFFF);
    run_frame(16'hFFFF);
    run_frame(16'hFFFF);
    check("t3 pos lane0", code(0), 127);
    check("t3 pos lane15", code(15), 127);
    check("t3 pos sat_flag", 32'(sat_flag), 32'h0000_FFFF);
    do_flush();
    run_frame(16'h0000);
    check("t3 neg lane0", code(0), -128);
    check("t3 neg lane15", code(15), -128);
    check("t3 neg sat_flag", 32'(sat_flag), 32'h0000_FFFF);
    shift = '0;

    // A tap written in the same cycle as a frame is not yet seen by that frame.
    broadcast_all(8'sd0);
    coef_we = 1'b1; coef_bcast = 1'b0; coef_lane = 4'd3; coef_tap = 5'd0; coef_data = -8'sd7;
    in_valid = 1'b1; bits_in = 16'hFFFF;
    tick();
    coef_we = 1'b0; in_valid = 1'b0; bits_in = '0;
    tick();
    check("t4 same-cycle lane3", code(3), 0);
    check("t4 same-cycle sat_flag", 32'(sat_flag), 0);
    run_frame(16'hFFFF);
    check("t4 next lane3", code(3), -7);
    check("t4 next lane2", code(2), 0);
    check("t4 next lane4", code(4), 0);

    // Valid gaps: frames at cycles 0, 3, 4; history advances only on those frames.
    write_tap(1'b0, 4'd0, 5'd1, 8'sd5);
    in_valid = 1'b1; bits_in = 16'h8000;
    tick();
    in_valid = 1'b0; bits_in = '0;
    check("t5 c1 out_valid", 32'(out_valid), 0);
    tick();
    check("t5 c2 out_valid", 32'(out_valid), 1);
    check("t5 c2 lane0", code(0), 5);
    tick();
    check("t5 c3 out_valid", 32'(out_valid), 0);
    in_valid = 1'b1; bits_in = 16'h0000;
    tick();
    check("t5 c4 out_valid", 32'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    check("t5 c5 out_valid", 32'(out_valid), 1);
    check("t5 c5 lane0", code(0), 5);
    tick();
    check("t5 c6 out_valid", 32'(out_valid), 1);
    check("t5 c6 lane0", code(0), -5);
    tick();
    check("t5 c7 out_valid", 32'(out_valid), 0);

    // Asynchronous reset with two frames in flight.
    in_valid = 1'b1; bits_in = 16'hFFFF;
    tick();
    tick();
    in_valid = 1'b0; bits_in = '0;
    check("t6 pre-reset out_valid", 32'(out_valid), 1);
    check("t6 pre-reset lane3", code(3), -7);
    rstb = 1'b0;
    #2;
    check("t6 reset out_valid", 32'(out_valid), 0);
    check("t6 reset lane3", code(3), 0);
    check("t6 reset sat_flag", 32'(sat_flag), 0);
    tick();
    check("t6 held out_valid", 32'(out_valid), 0);
    rstb = 1'b1;
    tick();
    run_frame(16'hFFFF);
    check("t6 post out_valid", 32'(out_valid), 1);
    check("t6 post lane0", code(0), 0);
    check("t6 post lane3", code(3), 0);
    tick();
    check("t6 post pulse end", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
